// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM with memory handshake and timeout watchdog
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   opcode            instr[31:26]; only looked at while in ID
//   zero              ALU zero flag; the datapath combines it with PCWriteCond
//   mem_ready         memory finishes the current access this cycle
//   PCWrite .. PCSource   datapath mux selects, write enables and memory strobes
//   state             current state code (debug)
//   illegal           high during the ID cycle of an unsupported opcode
//   err               high while parked in ERR after a memory timeout
module mc_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUop,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal,
    output logic       err
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_EXE  = 4'd6,
        S_RWB  = 4'd7,
        S_BEQ  = 4'd8,
        S_JMP  = 4'd9,
        S_ERR  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_sw;   // lw/sw choice latched in ID, since opcode is ignored afterwards

    state_t w_next;
    state_t w_dec;
    logic   w_waiting;
    logic   w_timeout;
    logic   w_unused_zero;

    // zero only gates the PC load together with PCWriteCond out in the datapath.
    assign w_unused_zero = zero;

    assign state     = r_state;
    assign w_waiting = ((r_state == S_IF) || (r_state == S_MRD) || (r_state == S_MWR)) && !mem_ready;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    // While rst is high the outputs already show the IF decode, so no stale
    // strobe from an interrupted instruction reaches memory or the regfile.
    assign w_dec = rst ? S_IF : r_state;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IF: begin
                if (mem_ready)      w_next = S_ID;
                else if (w_timeout) w_next = S_ERR;
            end
            S_ID: begin
                case (opcode)
                    OP_RTYPE:     w_next = S_EXE;
                    OP_LW, OP_SW: w_next = S_MADR;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_J:         w_next = S_JMP;
                    default:      w_next = S_IF;
                endcase
            end
            S_MADR: w_next = r_is_sw ? S_MWR : S_MRD;
            S_MRD: begin
                if (mem_ready)      w_next = S_MWB;
                else if (w_timeout) w_next = S_ERR;
            end
            S_MWR: begin
                if (mem_ready)      w_next = S_IF;
                else if (w_timeout) w_next = S_ERR;
            end
            S_EXE:   w_next = S_RWB;
            S_MWB,
            S_RWB,
            S_BEQ,
            S_JMP:   w_next = S_IF;
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IF;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUop       = 2'b00;
        PCSource    = 2'b00;
        illegal     = 1'b0;
        err         = 1'b0;
        case (w_dec)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // PC+4 and IR load only on the cycle the fetch completes.
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_ID: begin
                ALUSrcB = 2'b11;
                illegal = !((opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                            (opcode == OP_BEQ) || (opcode == OP_J));
            end
            S_MADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXE: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b10;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUop       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IF;
            r_cnt   <= '0;
            r_is_sw <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_waiting)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == S_ID)
                r_is_sw <= (opcode == OP_SW);
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl
module tb_mc_ctrl;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUop, PCSource;
    logic [3:0] state;
    logic       illegal, err;

    mc_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
        .PCSource(PCSource), .state(state), .illegal(illegal), .err(err)
    );

    always #5 clk = ~clk;

    logic [17:0] w_ctrl;
    assign w_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, illegal, err};

    function automatic logic [17:0] mk(input logic pcw, input logic pcwc, input logic iord,
                                       input logic mrd, input logic mwr, input logic irw,
                                       input logic m2r, input logic rdst, input logic rwr,
                                       input logic sa, input logic [1:0] sb, input logic [1:0] aop,
                                       input logic [1:0] psrc, input logic ill, input logic er);
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, sa, sb, aop, psrc, ill, er};
    endfunction

    localparam logic [17:0] C_IF0   = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0);
    localparam logic [17:0] C_IF1   = mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0);
    localparam logic [17:0] C_ID    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0);
    localparam logic [17:0] C_IDILL = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1,1'b0);
    localparam logic [17:0] C_MADR  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0);
    localparam logic [17:0] C_MRD   = mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    localparam logic [17:0] C_MWB   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    localparam logic [17:0] C_MWR   = mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    localparam logic [17:0] C_EXE   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0);
    localparam logic [17:0] C_RWB   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    localparam logic [17:0] C_BEQ   = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b0);
    localparam logic [17:0] C_JMP   = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0,1'b0);
    localparam logic [17:0] C_ERR   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1);

    int compared = 0;
    int failed   = 0;

    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] ctl;
    } vec_t;

    vec_t tab[25];

    function automatic vec_t mkv(input logic r, input logic [5:0] op, input logic z, input logic mr,
                                 input logic [3:0] st, input logic [17:0] ctl);
        vec_t v;
        v.r = r; v.op = op; v.z = z; v.mr = mr; v.st = st; v.ctl = ctl;
        return v;
    endfunction

    // One clock: drive on the falling edge, check just after, then let the rising edge act.
    task automatic step(input logic r, input logic [5:0] op, input logic z, input logic mr,
                        input logic [3:0] est, input logic [17:0] ectl, input string nm);
        @(negedge clk);
        rst = r; opcode = op; zero = z; mem_ready = mr;
        #1;
        compared++;
        if (state !== est) begin
            failed++;
            $display("FAIL %s state: got %0d want %0d", nm, state, est);
        end
        compared++;
        if (w_ctrl !== ectl) begin
            failed++;
            $display("FAIL %s ctrl: got %05h want %05h", nm, w_ctrl, ectl);
        end
        @(posedge clk);
    endtask

    // Reference model: an instruction is a path of state codes; memory-facing
    // steps may stall on mem_ready and time out after TIMEOUT stalled cycles.
    int m_state, m_wait, m_idx, m_len;
    int m_path[5];

    function automatic logic legal(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h02);
    endfunction

    function automatic logic [17:0] exp_ctrl(input int st, input logic mr, input logic [5:0] op, input logic r);
        int s;
        s = r ? 0 : st;
        case (s)
            0:       return mr ? C_IF1 : C_IF0;
            1:       return legal(op) ? C_ID : C_IDILL;
            2:       return C_MADR;
            3:       return C_MRD;
            4:       return C_MWB;
            5:       return C_MWR;
            6:       return C_EXE;
            7:       return C_RWB;
            8:       return C_BEQ;
            9:       return C_JMP;
            15:      return C_ERR;
            default: return 18'd0;
        endcase
    endfunction

    task automatic set_path(input int a, input int b, input int c, input int d, input int e, input int n);
        m_path[0] = a; m_path[1] = b; m_path[2] = c; m_path[3] = d; m_path[4] = e; m_len = n;
    endtask

    task automatic model_step(input logic r, input logic [5:0] op, input logic mr);
        if (r) begin
            m_state = 0; m_wait = 0; m_idx = 0;
            set_path(0, 1, 0, 0, 0, 2);
        end else if (m_state == 15) begin
            m_state = 15;
        end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mr) begin
            if (m_wait == TIMEOUT - 1) begin
                m_state = 15; m_wait = 0;
            end else begin
                m_wait++;
            end
        end else begin
            if (m_state == 1) begin
                case (op)
                    6'h00:   set_path(0, 1, 6, 7, 0, 4);
                    6'h23:   set_path(0, 1, 2, 3, 4, 5);
                    6'h2B:   set_path(0, 1, 2, 5, 0, 4);
                    6'h04:   set_path(0, 1, 8, 0, 0, 3);
                    6'h02:   set_path(0, 1, 9, 0, 0, 3);
                    default: set_path(0, 1, 0, 0, 0, 2);
                endcase
            end
            m_idx++;
            if (m_idx >= m_len) m_idx = 0;
            m_state = m_path[m_idx];
            m_wait = 0;
        end
    endtask

    logic [5:0] ops[6];

    initial begin
        tab[0]  = mkv(1'b1, 6'h00, 1'b0, 1'b1, 4'd0, C_IF1);
        tab[1]  = mkv(1'b0, 6'h00, 1'b0, 1'b1, 4'd0, C_IF1);
        tab[2]  = mkv(1'b0, 6'h00, 1'b0, 1'b1, 4'd1, C_ID);
        tab[3]  = mkv(1'b0, 6'h3F, 1'b0, 1'b1, 4'd6, C_EXE);
        tab[4]  = mkv(1'b0, 6'h2B, 1'b0, 1'b1, 4'd7, C_RWB);
        tab[5]  = mkv(1'b0, 6'h23, 1'b0, 1'b1, 4'd0, C_IF1);
        tab[6]  = mkv(1'b0, 6'h23, 1'b0, 1'b1, 4'd1, C_ID);
        tab[7]  = mkv(1'b0, 6'h2B, 1'b0, 1'b1, 4'd2, C_MADR);
        tab[8]  = mkv(1'b0, 6'h23, 1'b0, 1'b0, 4'd3, C_MRD);
        tab[9]  = mkv(1'b0, 6'h23, 1'b0, 1'b0, 4'd3, C_MRD);
        tab[10] = mkv(1'b0, 6'h23, 1'b0, 1'b0, 4'd3, C_MRD);
        tab[11] = mkv(1'b0, 6'h23, 1'b0, 1'b1, 4'd3, C_MRD);
        tab[12] = mkv(1'b0, 6'h23, 1'b0, 1'b1, 4'd4, C_MWB);
        tab[13] = mkv(1'b0, 6'h04, 1'b1, 1'b1, 4'd0, C_IF1);
        tab[14] = mkv(1'b0, 6'h04, 1'b1, 1'b1, 4'd1, C_ID);
        tab[15] = mkv(1'b0, 6'h04, 1'b1, 1'b1, 4'd8, C_BEQ);
        tab[16] = mkv(1'b0, 6'h04, 1'b0, 1'b1, 4'd0, C_IF1);
        tab[17] = mkv(1'b0, 6'h04, 1'b0, 1'b1, 4'd1, C_ID);
        tab[18] = mkv(1'b0, 6'h04, 1'b0, 1'b1, 4'd8, C_BEQ);
        tab[19] = mkv(1'b0, 6'h3F, 1'b0, 1'b1, 4'd0, C_IF1);
        tab[20] = mkv(1'b0, 6'h3F, 1'b0, 1'b1, 4'd1, C_IDILL);
        tab[21] = mkv(1'b0, 6'h02, 1'b0, 1'b1, 4'd0, C_IF1);
        tab[22] = mkv(1'b0, 6'h02, 1'b0, 1'b1, 4'd1, C_ID);
        tab[23] = mkv(1'b0, 6'h02, 1'b0, 1'b1, 4'd9, C_JMP);
        tab[24] = mkv(1'b0, 6'h00, 1'b0, 1'b0, 4'd0, C_IF0);

        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
        ops[3] = 6'h04; ops[4] = 6'h02; ops[5] = 6'h3F;

        // Initial reset with unknown prior state: not checked.
        repeat (2) @(posedge clk);

        for (int i = 0; i < 25; i++)
            step(tab[i].r, tab[i].op, tab[i].z, tab[i].mr, tab[i].st, tab[i].ctl, $sformatf("tab%0d", i));

        // Timeout in IF: 16 stalled cycles after reset, then ERR until rst.
        step(1'b1, 6'h00, 1'b0, 1'b0, 4'd0, C_IF0, "to_rst");
        for (int i = 0; i < TIMEOUT; i++)
            step(1'b0, 6'h00, 1'b0, 1'b0, 4'd0, C_IF0, $sformatf("to_wait%0d", i));
        for (int i = 0; i < 3; i++)
            step(1'b0, 6'h00, 1'b0, 1'b1, 4'd15, C_ERR, "to_err");
        step(1'b1, 6'h00, 1'b0, 1'b1, 4'd15, C_IF1, "to_rst_err");
        step(1'b0, 6'h00, 1'b0, 1'b1, 4'd0, C_IF1, "to_after_rst");
        step(1'b0, 6'h3F, 1'b0, 1'b1, 4'd1, C_IDILL, "ill2");

        // mem_ready on the final allowed cycle wins over the timeout.
        for (int i = 0; i < TIMEOUT - 1; i++)
            step(1'b0, 6'h00, 1'b0, 1'b0, 4'd0, C_IF0, "win_wait");
        step(1'b0, 6'h00, 1'b0, 1'b1, 4'd0, C_IF1, "win_last");

        // sw interrupted by rst in MWR; the wait counter must restart from zero.
        step(1'b0, 6'h2B, 1'b0, 1'b1, 4'd1, C_ID, "sw_id");
        step(1'b0, 6'h00, 1'b0, 1'b1, 4'd2, C_MADR, "sw_madr");
        step(1'b0, 6'h00, 1'b0, 1'b0, 4'd5, C_MWR, "sw_wait");
        step(1'b0, 6'h00, 1'b0, 1'b0, 4'd5, C_MWR, "sw_wait");
        step(1'b1, 6'h00, 1'b0, 1'b0, 4'd5, C_IF0, "sw_rst");
        for (int i = 0; i < TIMEOUT; i++)
            step(1'b0, 6'h00, 1'b0, 1'b0, 4'd0, C_IF0, $sformatf("sw_clr%0d", i));
        step(1'b1, 6'h00, 1'b0, 1'b1, 4'd15, C_IF1, "sw_err_rst");

        // Randomized run against the reference model.
        m_state = 0; m_wait = 0; m_idx = 0;
        set_path(0, 1, 0, 0, 0, 2);
        begin
            int burst;
            logic r, z, mr;
            logic [5:0] op;
            burst = 0;
            for (int i = 0; i < 3000; i++) begin
                r  = ($urandom_range(0, 63) == 0);
                op = ops[$urandom_range(0, 5)];
                if (op == 6'h3F) op = 6'($urandom_range(0, 63));
                z  = 1'($urandom_range(0, 1));
                if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(14, 18);
                if (burst > 0) begin
                    mr = 1'b0;
                    burst--;
                end else begin
                    mr = ($urandom_range(0, 3) != 0);
                end
                step(r, op, z, mr, 4'(m_state), exp_ctrl(m_state, mr, op, r), "rnd");
                model_step(r, op, mr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
